// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending coin-credit controller.
//   vend_state_t : controller states (IDLE, COLLECT, DISPENSE, CHANGE)
//   COIN_*       : coin_type encodings from the coin decoder
//   coin_value() : maps a coin_type to its credit value (0 for the invalid code)
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } vend_state_t;

  localparam logic [1:0] COIN_50C = 2'b00;
  localparam logic [1:0] COIN_1E  = 2'b01;
  localparam logic [1:0] COIN_2E  = 2'b10;
  localparam logic [1:0] COIN_INV = 2'b11;

  // Denomination values are passed in because they are parameters of the
  // instantiating module, not of the package.
  function automatic int unsigned coin_value(input logic [1:0]  coin_type,
                                             input int unsigned v0,
                                             input int unsigned v1,
                                             input int unsigned v2);
    case (coin_type)
      COIN_50C: return v0;
      COIN_1E:  return v1;
      COIN_2E:  return v2;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/vend_timeout_ctr.sv
// Inactivity timer for the COLLECT state.
// Counts enabled cycles since the last clear; o_expired is asserted during
// the TIMEOUT-th consecutive enabled cycle so the controller can leave on
// the clock edge that ends it. TIMEOUT = 0 disables expiry entirely.
// Ports:
//   clk       in  clock, rising edge
//   rst_n     in  synchronous active-low reset
//   i_clear   in  restart the count (takes priority over i_enable)
//   i_enable  in  count this cycle
//   o_expired out timeout reached this cycle (combinational)
module vend_timeout_ctr #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  // At least one bit so the TIMEOUT = 0 build still elaborates cleanly.
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expired = (TIMEOUT != 0) && i_enable && (r_count == LAST);

endmodule

// File: rtl/vend_credit_fsm.sv
// Coin-credit controller for the beverage vending demo.
// Accumulates credit from three coin denominations, requests a dispense once
// PRICE is reached, returns change over a valid/ready handshake and refunds
// on cancel or after TIMEOUT idle cycles in COLLECT.
// Ports:
//   clk, rst_n     clock (rising edge) and synchronous active-low reset
//   coin_valid     one-cycle pulse: coin inserted
//   coin_type      denomination, sampled with coin_valid (2'b11 invalid)
//   cancel         refund request (honoured only in COLLECT)
//   dispense_ack   dispenser delivered the beverage
//   change_ready   coin return unit accepts change_amount
//   dispense_req   high while in DISPENSE
//   change_valid   high while in CHANGE
//   change_amount  amount to return, stable while change_valid
//   coin_reject    one-cycle pulse, one cycle after a coin that was not credited
//   credit         current accumulated credit
//   busy           high in any state other than IDLE
module vend_credit_fsm
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W  = 8,
  parameter int unsigned PRICE     = 15,
  parameter int unsigned COIN0_VAL = 5,
  parameter int unsigned COIN1_VAL = 10,
  parameter int unsigned COIN2_VAL = 20,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                cancel,
  input  logic                dispense_ack,
  input  logic                change_ready,
  output logic                dispense_req,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int unsigned MAX01    = (COIN0_VAL > COIN1_VAL) ? COIN0_VAL : COIN1_VAL;
  localparam int unsigned MAX_COIN = (MAX01 > COIN2_VAL) ? MAX01 : COIN2_VAL;
  localparam logic [CREDIT_W-1:0] LP_PRICE = CREDIT_W'(PRICE);

  // Credit never exceeds PRICE-1 before a coin is added, so PRICE+MAX_COIN-1
  // fitting in CREDIT_W bits rules out any wrap in the adder.
  if (PRICE == 0) begin : g_price_err
    $error("vend_credit_fsm: PRICE must be non-zero");
  end
  if ((64'(PRICE) + 64'(MAX_COIN) - 64'd1) >= (64'd1 << CREDIT_W)) begin : g_width_err
    $error("vend_credit_fsm: CREDIT_W too small for PRICE + largest coin - 1");
  end

  vend_state_t         r_state;
  vend_state_t         w_state_nxt;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic [CREDIT_W-1:0] r_change_amt;
  logic [CREDIT_W-1:0] w_change_nxt;
  logic                r_coin_reject;
  logic                w_reject_nxt;

  logic                w_coin_ok;
  logic [CREDIT_W-1:0] w_coin_val;
  logic [CREDIT_W-1:0] w_sum;
  logic [CREDIT_W-1:0] w_remainder;
  logic                w_tmr_en;
  logic                w_tmr_clr;
  logic                w_tmr_expired;

  assign w_coin_ok   = coin_valid && (coin_type != COIN_INV);
  assign w_coin_val  = CREDIT_W'(coin_value(coin_type, COIN0_VAL, COIN1_VAL, COIN2_VAL));
  assign w_sum       = r_credit + w_coin_val;
  // Only used in DISPENSE, where credit >= PRICE always holds.
  assign w_remainder = r_credit - LP_PRICE;

  // Any accepted coin restarts the inactivity window.
  assign w_tmr_en  = (r_state == COLLECT);
  assign w_tmr_clr = (r_state != COLLECT) || w_coin_ok;

  vend_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_tmr_clr),
    .i_enable  (w_tmr_en),
    .o_expired (w_tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_credit      <= '0;
      r_change_amt  <= '0;
      r_coin_reject <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_credit      <= w_credit_nxt;
      r_change_amt  <= w_change_nxt;
      r_coin_reject <= w_reject_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_change_nxt = r_change_amt;
    // Invalid denominations bounce in every state.
    w_reject_nxt = coin_valid && (coin_type == COIN_INV);

    case (r_state)
      IDLE: begin
        if (w_coin_ok) begin
          w_credit_nxt = w_coin_val;
          w_state_nxt  = (w_coin_val >= LP_PRICE) ? DISPENSE : COLLECT;
        end
      end
      COLLECT: begin
        // Priority: cancel, then coin, then timeout.
        if (cancel) begin
          w_state_nxt  = CHANGE;
          w_change_nxt = r_credit;
          w_reject_nxt = coin_valid;
        end else if (w_coin_ok) begin
          w_credit_nxt = w_sum;
          if (w_sum >= LP_PRICE) begin
            w_state_nxt = DISPENSE;
          end
        end else if (w_tmr_expired) begin
          w_state_nxt  = CHANGE;
          w_change_nxt = r_credit;
        end
      end
      DISPENSE: begin
        w_reject_nxt = coin_valid;
        if (dispense_ack) begin
          if (w_remainder != '0) begin
            w_state_nxt  = CHANGE;
            w_credit_nxt = w_remainder;
            w_change_nxt = w_remainder;
          end else begin
            w_state_nxt  = IDLE;
            w_credit_nxt = '0;
          end
        end
      end
      CHANGE: begin
        w_reject_nxt = coin_valid;
        if (change_ready) begin
          w_state_nxt  = IDLE;
          w_credit_nxt = '0;
          w_change_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign dispense_req  = (r_state == DISPENSE);
  assign change_valid  = (r_state == CHANGE);
  assign change_amount = r_change_amt;
  assign coin_reject   = r_coin_reject;
  assign credit        = r_credit;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Bench for vend_credit_fsm: directed scenarios plus a randomized run
// checked against a behavioural model of the vending rules.
module tb_vend_credit_fsm;

  localparam int PRICE = 15;
  localparam int TMO   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'b00;
  logic       cancel = 1'b0;
  logic       dispense_ack = 1'b0;
  logic       change_ready = 1'b0;
  logic       dispense_req;
  logic       change_valid;
  logic [7:0] change_amount;
  logic       coin_reject;
  logic [7:0] credit;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase 0 idle, 1 collecting, 2 dispensing, 3 returning change.
  int vals[3] = '{5, 10, 20};
  int m_phase, m_credit, m_amt, m_idle;
  bit m_rej;

  always #5 clk = ~clk;

  vend_credit_fsm #(
    .CREDIT_W(8), .PRICE(15), .COIN0_VAL(5), .COIN1_VAL(10), .COIN2_VAL(20), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_type(coin_type),
    .cancel(cancel), .dispense_ack(dispense_ack), .change_ready(change_ready),
    .dispense_req(dispense_req), .change_valid(change_valid), .change_amount(change_amount),
    .coin_reject(coin_reject), .credit(credit), .busy(busy)
  );

  task automatic model_reset();
    m_phase = 0; m_credit = 0; m_amt = 0; m_idle = 0; m_rej = 0;
  endtask

  task automatic model_step(input bit cv, input bit [1:0] ct, input bit cn,
                            input bit ak, input bit rd);
    bit good;
    int val;
    good  = cv && (ct != 2'b11);
    val   = good ? vals[ct] : 0;
    m_rej = cv && (ct == 2'b11);
    if (m_phase == 0) begin
      if (good) begin
        m_credit = val;
        m_idle   = 0;
        m_phase  = (val >= PRICE) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      if (cn) begin
        m_rej = cv; m_amt = m_credit; m_phase = 3;
      end else if (good) begin
        m_credit += val;
        m_idle = 0;
        if (m_credit >= PRICE) m_phase = 2;
      end else begin
        m_idle++;
        if (m_idle == TMO) begin m_amt = m_credit; m_phase = 3; end
      end
    end else if (m_phase == 2) begin
      m_rej = cv;
      if (ak) begin
        m_credit -= PRICE;
        if (m_credit > 0) begin m_amt = m_credit; m_phase = 3; end
        else m_phase = 0;
      end
    end else begin
      m_rej = cv;
      if (rd) begin m_phase = 0; m_credit = 0; m_amt = 0; end
    end
  endtask

  // Drive one clock of inputs, advance the model, land 1 ns after the edge.
  task automatic step(input bit cv, input bit [1:0] ct, input bit cn,
                      input bit ak, input bit rd);
    @(negedge clk);
    rst_n = 1'b1;
    coin_valid = cv; coin_type = ct; cancel = cn; dispense_ack = ak; change_ready = rd;
    model_step(cv, ct, cn, ak, rd);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    coin_valid = 0; coin_type = 0; cancel = 0; dispense_ack = 0; change_ready = 0;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    n_tests++;
    if ({busy, dispense_req, change_valid, coin_reject} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {busy, dispense_req, change_valid, coin_reject});
    end
    n_tests++;
    if ({credit, change_amount} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_values: credit %0d amount %0d want 0 0", credit, change_amount);
    end
  endtask

  task automatic test_three_50c();
    step(1, 2'b00, 0, 0, 0);
    n_tests++;
    if (credit !== 8'd5 || busy !== 1'b1) begin
      n_fail++; $display("FAIL 50c_first: credit %0d busy %b want 5 1", credit, busy);
    end
    step(1, 2'b00, 0, 0, 0);
    n_tests++;
    if (credit !== 8'd10 || dispense_req !== 1'b0) begin
      n_fail++; $display("FAIL 50c_second: credit %0d req %b want 10 0", credit, dispense_req);
    end
    step(1, 2'b00, 0, 0, 0);
    n_tests++;
    if (credit !== 8'd15 || dispense_req !== 1'b1) begin
      n_fail++; $display("FAIL 50c_third: credit %0d req %b want 15 1", credit, dispense_req);
    end
    step(0, 2'b00, 0, 1, 0);
    n_tests++;
    if ({busy, change_valid, dispense_req} !== 3'b000 || credit !== 8'd0) begin
      n_fail++; $display("FAIL 50c_ack: busy/cv/req %b credit %0d want 000 0", {busy, change_valid, dispense_req}, credit);
    end
  endtask

  task automatic test_two_1e();
    step(1, 2'b01, 0, 0, 0);
    step(1, 2'b01, 0, 0, 0);
    n_tests++;
    if (credit !== 8'd20 || dispense_req !== 1'b1) begin
      n_fail++; $display("FAIL 1e_pair: credit %0d req %b want 20 1", credit, dispense_req);
    end
    step(0, 2'b00, 0, 1, 0);
    n_tests++;
    if (change_valid !== 1'b1 || change_amount !== 8'd5 || dispense_req !== 1'b0) begin
      n_fail++; $display("FAIL 1e_change: valid %b amount %0d req %b want 1 5 0", change_valid, change_amount, dispense_req);
    end
    step(0, 2'b00, 0, 0, 0);
    n_tests++;
    if (change_valid !== 1'b1 || change_amount !== 8'd5) begin
      n_fail++; $display("FAIL 1e_change_hold: valid %b amount %0d want 1 5", change_valid, change_amount);
    end
    step(0, 2'b00, 0, 0, 1);
    n_tests++;
    if (busy !== 1'b0 || change_valid !== 1'b0 || credit !== 8'd0) begin
      n_fail++; $display("FAIL 1e_done: busy %b valid %b credit %0d want 0 0 0", busy, change_valid, credit);
    end
  endtask

  task automatic test_2e_direct();
    step(1, 2'b10, 0, 0, 0);
    n_tests++;
    if (dispense_req !== 1'b1 || credit !== 8'd20) begin
      n_fail++; $display("FAIL 2e_direct: req %b credit %0d want 1 20", dispense_req, credit);
    end
    step(0, 2'b00, 0, 1, 0);
    n_tests++;
    if (change_valid !== 1'b1 || change_amount !== 8'd5) begin
      n_fail++; $display("FAIL 2e_change: valid %b amount %0d want 1 5", change_valid, change_amount);
    end
    step(0, 2'b00, 0, 0, 1);
  endtask

  task automatic test_cancel_with_coin();
    step(1, 2'b00, 0, 0, 0);
    step(1, 2'b01, 1, 0, 0);
    n_tests++;
    if (coin_reject !== 1'b1 || change_valid !== 1'b1 || change_amount !== 8'd5 || credit !== 8'd5) begin
      n_fail++; $display("FAIL cancel_coin: rej %b valid %b amount %0d credit %0d want 1 1 5 5",
                         coin_reject, change_valid, change_amount, credit);
    end
    step(0, 2'b00, 0, 0, 1);
    n_tests++;
    if (coin_reject !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL cancel_done: rej %b busy %b want 0 0", coin_reject, busy);
    end
  endtask

  task automatic test_timeout_and_dispense_reject();
    step(1, 2'b00, 0, 0, 0);
    for (int i = 0; i < TMO - 1; i++) step(0, 2'b00, 0, 0, 0);
    n_tests++;
    if (change_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL timeout_early: valid %b busy %b want 0 1", change_valid, busy);
    end
    step(0, 2'b00, 0, 0, 0);
    n_tests++;
    if (change_valid !== 1'b1 || change_amount !== 8'd5) begin
      n_fail++; $display("FAIL timeout_refund: valid %b amount %0d want 1 5", change_valid, change_amount);
    end
    step(0, 2'b00, 0, 0, 1);
    step(1, 2'b10, 0, 0, 0);
    step(1, 2'b00, 0, 0, 0);
    n_tests++;
    if (coin_reject !== 1'b1 || credit !== 8'd20 || dispense_req !== 1'b1) begin
      n_fail++; $display("FAIL dispense_reject: rej %b credit %0d req %b want 1 20 1", coin_reject, credit, dispense_req);
    end
    step(0, 2'b00, 1, 0, 0);
    n_tests++;
    if (dispense_req !== 1'b1 || coin_reject !== 1'b0) begin
      n_fail++; $display("FAIL dispense_cancel: req %b rej %b want 1 0", dispense_req, coin_reject);
    end
    step(0, 2'b00, 0, 1, 0);
    step(0, 2'b00, 0, 0, 1);
  endtask

  task automatic test_invalid_and_reset_in_change();
    step(1, 2'b11, 0, 0, 0);
    n_tests++;
    if (coin_reject !== 1'b1 || busy !== 1'b0 || credit !== 8'd0) begin
      n_fail++; $display("FAIL invalid_coin: rej %b busy %b credit %0d want 1 0 0", coin_reject, busy, credit);
    end
    step(0, 2'b00, 0, 0, 0);
    n_tests++;
    if (coin_reject !== 1'b0) begin
      n_fail++; $display("FAIL invalid_pulse: rej %b want 0", coin_reject);
    end
    step(1, 2'b01, 0, 0, 0);
    step(1, 2'b01, 0, 0, 0);
    step(0, 2'b00, 0, 1, 0);
    do_reset();
    n_tests++;
    if ({busy, dispense_req, change_valid, coin_reject} !== 4'b0000 || credit !== 8'd0 || change_amount !== 8'd0) begin
      n_fail++; $display("FAIL reset_in_change: flags %b credit %0d amount %0d want 0000 0 0",
                         {busy, dispense_req, change_valid, coin_reject}, credit, change_amount);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 99) < 40), 2'($urandom_range(0, 3)), ($urandom_range(0, 99) < 8),
             ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 35));
      end
      n_tests++;
      if ({dispense_req, change_valid, coin_reject, busy} !== {m_phase == 2, m_phase == 3, m_rej, m_phase != 0}) begin
        n_fail++; $display("FAIL rand_flags cyc %0d: req/cv/rej/busy %b want %b", i,
                           {dispense_req, change_valid, coin_reject, busy},
                           {m_phase == 2, m_phase == 3, m_rej, m_phase != 0});
      end
      n_tests++;
      if (credit !== 8'(m_credit)) begin
        n_fail++; $display("FAIL rand_credit cyc %0d: got %0d want %0d", i, credit, m_credit);
      end
      n_tests++;
      if (change_valid && change_amount !== 8'(m_amt)) begin
        n_fail++; $display("FAIL rand_amount cyc %0d: got %0d want %0d", i, change_amount, m_amt);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_three_50c();
    test_two_1e();
    test_2e_direct();
    test_cancel_with_coin();
    test_timeout_and_dispense_reject();
    test_invalid_and_reset_in_change();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
